adsr_poly_envelope: RTL and testbench

ADSR_POLY_ENVELOPE -- requirements
Module: adsr_poly_envelope

---
 rtl/adsr_poly_envelope.sv | 180 ++++++++++++++++++
 tb/tb_adsr_poly_envelope.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_poly_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_poly_envelope
// Description : Polyphonic ADSR envelope generator with one shared rate tick
//               and shared a/d/s/r controls.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_poly_envelope #(
    parameter int NUM_VOICES    = 4,
    parameter int CONTROL_WIDTH = 10,
    parameter int OUTPUT_WIDTH  = 10,
    parameter int TICK_DIV      = 50,
    parameter int RETRIG_LEGATO = 0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_VOICES-1:0]              gate,
    input  logic [CONTROL_WIDTH-1:0]           a,
    input  logic [CONTROL_WIDTH-1:0]           d,
    input  logic [CONTROL_WIDTH-1:0]           s,
    input  logic [CONTROL_WIDTH-1:0]           r,
    output logic [NUM_VOICES*OUTPUT_WIDTH-1:0] envelope,
    output logic [NUM_VOICES-1:0]              active,
    output logic [NUM_VOICES-1:0]              done
);

    localparam int                      TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]       TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [OUTPUT_WIDTH-1:0] LEVEL_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    logic [TICK_W-1:0]       tick_cnt;
    logic                    tick;
    logic [OUTPUT_WIDTH-1:0] sus;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Sustain control is MSB-aligned onto the level range.
    generate
        if (OUTPUT_WIDTH >= CONTROL_WIDTH) begin : g_sus_widen
            assign sus = OUTPUT_WIDTH'(s) << (OUTPUT_WIDTH - CONTROL_WIDTH);
        end else begin : g_sus_narrow
            assign sus = OUTPUT_WIDTH'(s >> (CONTROL_WIDTH - OUTPUT_WIDTH));
        end
    endgenerate

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            state_t                  state_q, state_d;
            logic [OUTPUT_WIDTH-1:0] level_q, level_d;
            logic [CONTROL_WIDTH-1:0] rc_q, rc_d, rc_adv, rate;
            logic                    gate_q, rise, fall, step, finish;
            logic [OUTPUT_WIDTH-1:0] env_q;
            logic                    act_q, done_q;

            assign rise = gate[v] & ~gate_q;
            assign fall = ~gate[v] & gate_q;

            always_comb begin
                case (state_q)
                    ST_ATTACK: rate = a;
                    ST_DECAY:  rate = d;
                    default:   rate = r;
                endcase
            end

            // The >= compare lets a lowered rate take effect on the next tick.
            assign step   = tick && (rc_q >= rate);
            assign rc_adv = step ? '0 : (tick ? rc_q + CONTROL_WIDTH'(1) : rc_q);

            always_comb begin
                state_d = state_q;
                level_d = level_q;
                rc_d    = rc_q;
                finish  = 1'b0;
                if (rise) begin
                    state_d = ST_ATTACK;
                    rc_d    = '0;
                    if (RETRIG_LEGATO == 0) begin
                        level_d = '0;
                    end
                end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                      state_q == ST_SUSTAIN)) begin
                    state_d = ST_RELEASE;
                    rc_d    = '0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            level_d = '0;
                        end
                        ST_ATTACK: begin
                            if (level_q == LEVEL_MAX) begin
                                state_d = ST_DECAY;
                                rc_d    = '0;
                            end else begin
                                rc_d = rc_adv;
                                if (step) begin
                                    level_d = level_q + OUTPUT_WIDTH'(1);
                                end
                            end
                        end
                        ST_DECAY: begin
                            if (level_q <= sus) begin
                                state_d = ST_SUSTAIN;
                                level_d = sus;
                                rc_d    = '0;
                            end else begin
                                rc_d = rc_adv;
                                if (step) begin
                                    level_d = level_q - OUTPUT_WIDTH'(1);
                                end
                            end
                        end
                        ST_SUSTAIN: begin
                            level_d = sus;
                        end
                        ST_RELEASE: begin
                            if (level_q == '0) begin
                                state_d = ST_IDLE;
                                rc_d    = '0;
                                finish  = 1'b1;
                            end else begin
                                rc_d = rc_adv;
                                if (step) begin
                                    level_d = level_q - OUTPUT_WIDTH'(1);
                                end
                            end
                        end
                        default: begin
                            state_d = ST_IDLE;
                            level_d = '0;
                            rc_d    = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= ST_IDLE;
                    level_q <= '0;
                    rc_q    <= '0;
                    gate_q  <= 1'b0;
                    env_q   <= '0;
                    act_q   <= 1'b0;
                    done_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    level_q <= level_d;
                    rc_q    <= rc_d;
                    gate_q  <= gate[v];
                    env_q   <= level_q;
                    act_q   <= (state_q != ST_IDLE);
                    done_q  <= finish;
                end
            end

            assign envelope[v*OUTPUT_WIDTH +: OUTPUT_WIDTH] = env_q;
            assign active[v] = act_q;
            assign done[v]   = done_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_adsr_poly_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_adsr_poly_envelope
// Description : Directed self-checking bench for adsr_poly_envelope.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adsr_poly_envelope;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] gate;
    logic [3:0] a, d, s, r;
    logic [7:0] env0, env_l, env_t;
    logic [1:0] act0, act_l, act_t;
    logic [1:0] done0, done_l, done_t;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    adsr_poly_envelope #(
        .NUM_VOICES(2), .CONTROL_WIDTH(4), .OUTPUT_WIDTH(4), .TICK_DIV(1), .RETRIG_LEGATO(0)
    ) dut (
        .clk(clk), .reset(reset), .gate(gate), .a(a), .d(d), .s(s), .r(r),
        .envelope(env0), .active(act0), .done(done0)
    );

    adsr_poly_envelope #(
        .NUM_VOICES(2), .CONTROL_WIDTH(4), .OUTPUT_WIDTH(4), .TICK_DIV(1), .RETRIG_LEGATO(1)
    ) dut_l (
        .clk(clk), .reset(reset), .gate(gate), .a(a), .d(d), .s(s), .r(r),
        .envelope(env_l), .active(act_l), .done(done_l)
    );

    adsr_poly_envelope #(
        .NUM_VOICES(2), .CONTROL_WIDTH(4), .OUTPUT_WIDTH(4), .TICK_DIV(2), .RETRIG_LEGATO(0)
    ) dut_t (
        .clk(clk), .reset(reset), .gate(gate), .a(a), .d(d), .s(s), .r(r),
        .envelope(env_t), .active(act_t), .done(done_t)
    );

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        gate  = 2'b00;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        gate  = 2'b11;
        cycle();
        checks++;
        if ({env0, env_l, env_t} !== 24'h0) begin
            fails++;
            $display("FAIL reset_env: got %h %h %h, want 00 00 00", env0, env_l, env_t);
        end
        checks++;
        if ({act0, act_l, act_t, done0, done_l, done_t} !== 12'h0) begin
            fails++;
            $display("FAIL reset_flags: active %b %b %b done %b %b %b, want all 0",
                     act0, act_l, act_t, done0, done_l, done_t);
        end
        reset = 1'b0;
        gate  = 2'b00;
    endtask

    task automatic test_attack_decay_sustain();
        int exp;
        do_reset();
        a = 4'd0; d = 4'd0; s = 4'd8; r = 4'd0;
        gate = 2'b01;
        for (int k = 0; k <= 30; k++) begin
            cycle();
            if (k == 0)       exp = 0;
            else if (k <= 16) exp = k - 1;
            else if (k == 17) exp = 15;
            else if (k <= 24) exp = 32 - k;
            else              exp = 8;
            checks++;
            if (env0[3:0] !== exp[3:0]) begin
                fails++;
                $display("FAIL ads_level k=%0d: got %0d, want %0d", k, env0[3:0], exp);
            end
        end
        checks++;
        if (act0 !== 2'b01 || env0[7:4] !== 4'd0) begin
            fails++;
            $display("FAIL ads_active: active=%b v1=%0d, want 01 and 0", act0, env0[7:4]);
        end
    endtask

    task automatic test_release();
        int exp;
        int pulses = 0;
        gate = 2'b00;
        for (int k = 0; k <= 14; k++) begin
            cycle();
            if (k <= 1)      exp = 8;
            else if (k <= 9) exp = 9 - k;
            else             exp = 0;
            checks++;
            if (env0[3:0] !== exp[3:0]) begin
                fails++;
                $display("FAIL rel_level k=%0d: got %0d, want %0d", k, env0[3:0], exp);
            end
            if (done0[0]) pulses++;
            if (k == 9) begin
                checks++;
                if (done0[0] !== 1'b1 || act0[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL rel_done_at_idle: done=%b active=%b, want 1 1", done0[0], act0[0]);
                end
            end
            if (k == 10) begin
                checks++;
                if (act0[0] !== 1'b0) begin
                    fails++;
                    $display("FAIL rel_inactive: active=%b, want 0", act0[0]);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            fails++;
            $display("FAIL rel_done_count: got %0d pulses, want 1", pulses);
        end
    endtask

    task automatic test_slow_attack();
        int prev = 0;
        int last_chg = -1;
        int c15 = -1;
        int bad = 0;
        do_reset();
        a = 4'd3; d = 4'd0; s = 4'd8; r = 4'd0;
        gate = 2'b01;
        for (int k = 0; k <= 200 && c15 < 0; k++) begin
            cycle();
            if (int'(env_t[3:0]) != prev) begin
                if (int'(env_t[3:0]) != prev + 1) bad++;
                if (last_chg < 0) begin
                    if (k != 8) bad++;
                end else if (k - last_chg != 8) begin
                    bad++;
                end
                last_chg = k;
                prev = int'(env_t[3:0]);
                if (prev == 15) c15 = k;
            end
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL slow_step_spacing: %0d irregular steps, want 0", bad);
        end
        checks++;
        if (c15 != 120) begin
            fails++;
            $display("FAIL slow_full_attack: reached 15 at cycle %0d, want 120", c15);
        end
    endtask

    task automatic test_release_mid_attack();
        bit found = 0;
        int peak = 0;
        int prev = 5;
        int rises = 0;
        int pulses = 0;
        do_reset();
        a = 4'd3; d = 4'd0; s = 4'd8; r = 4'd0;
        gate = 2'b01;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (env0[3:0] == 4'd5) found = 1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL mid_attack_wait: level 5 not seen, want within 60 cycles");
        end
        gate = 2'b00;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (int'(env0[3:0]) > peak) peak = int'(env0[3:0]);
            if (int'(env0[3:0]) > prev) rises++;
            prev = int'(env0[3:0]);
            if (done0[0]) pulses++;
        end
        checks++;
        if (peak != 5 || rises != 0) begin
            fails++;
            $display("FAIL mid_attack_release: peak=%0d rises=%0d, want 5 and 0", peak, rises);
        end
        checks++;
        if (env0[3:0] !== 4'd0 || act0[0] !== 1'b0 || pulses != 1) begin
            fails++;
            $display("FAIL mid_attack_idle: level=%0d active=%b done_pulses=%0d, want 0 0 1",
                     env0[3:0], act0[0], pulses);
        end
    endtask

    task automatic test_retrigger();
        bit found = 0;
        do_reset();
        a = 4'd0; d = 4'd0; s = 4'd15; r = 4'd3;
        gate = 2'b01;
        repeat (25) cycle();
        gate = 2'b00;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            if (env0[3:0] == 4'd6) found = 1;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL retrig_wait: level 6 not seen, want within 80 cycles");
        end
        gate = 2'b01;
        cycle();
        cycle();
        checks++;
        if (env0[3:0] !== 4'd0 || env_l[3:0] !== 4'd6) begin
            fails++;
            $display("FAIL retrig_first: restart=%0d legato=%0d, want 0 and 6", env0[3:0], env_l[3:0]);
        end
        cycle();
        checks++;
        if (env0[3:0] !== 4'd1 || env_l[3:0] !== 4'd7) begin
            fails++;
            $display("FAIL retrig_rise: restart=%0d legato=%0d, want 1 and 7", env0[3:0], env_l[3:0]);
        end
    endtask

    task automatic test_two_voices_and_reset();
        int pulses = 0;
        do_reset();
        a = 4'd0; d = 4'd0; s = 4'd8; r = 4'd0;
        gate = 2'b01;
        repeat (3) cycle();
        gate = 2'b11;
        repeat (40) cycle();
        checks++;
        if (env0 !== 8'h88 || act0 !== 2'b11) begin
            fails++;
            $display("FAIL two_sustain: env=%h active=%b, want 88 11", env0, act0);
        end
        s = 4'd12;
        repeat (3) cycle();
        checks++;
        if (env0 !== 8'hCC) begin
            fails++;
            $display("FAIL sustain_track: env=%h, want cc", env0);
        end
        gate = 2'b01;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (done0[0]) pulses++;
        end
        checks++;
        if (env0 !== 8'h0C || act0 !== 2'b01 || pulses != 0) begin
            fails++;
            $display("FAIL voice_isolation: env=%h active=%b v0_done=%0d, want 0c 01 0", env0, act0, pulses);
        end
        gate = 2'b00;
        repeat (20) cycle();
        gate = 2'b11;
        repeat (5) cycle();
        reset = 1'b1;
        cycle();
        checks++;
        if (env0 !== 8'h00 || act0 !== 2'b00 || done0 !== 2'b00) begin
            fails++;
            $display("FAIL mid_attack_reset: env=%h active=%b done=%b, want 00 00 00", env0, act0, done0);
        end
        cycle();
        reset = 1'b0;
        cycle();
        checks++;
        if (act0 !== 2'b00) begin
            fails++;
            $display("FAIL post_reset_first: active=%b, want 00", act0);
        end
        cycle();
        checks++;
        if (act0 !== 2'b11) begin
            fails++;
            $display("FAIL post_reset_rise: active=%b, want 11", act0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        gate  = 2'b00;
        a = 4'd0; d = 4'd0; s = 4'd0; r = 4'd0;
        test_reset();
        test_attack_decay_sustain();
        test_release();
        test_slow_attack();
        test_release_mid_attack();
        test_retrigger();
        test_two_voices_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
